// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder: serialises one DATA_W-bit message MSB first and
// presents the full 2*DATA_W-bit codeword on code_out with a one-cycle done pulse.
module conv_encoder #(
  parameter int unsigned DATA_W = 8,
  parameter logic [2:0]  G0     = 3'b111,
  parameter logic [2:0]  G1     = 3'b101
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_start,
  input  logic [DATA_W-1:0]     i_data_in,
  output logic [2*DATA_W-1:0]   o_code_out,
  output logic                  o_done_flag,
  output logic                  o_busy
);

  localparam int unsigned   CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StEncode, StDone} state_e;

  state_e                r_state, w_state_nxt;
  logic [DATA_W-1:0]     r_msg, w_msg_nxt;
  logic                  r_s1, w_s1_nxt;
  logic                  r_s2, w_s2_nxt;
  logic [CntW-1:0]       r_cnt, w_cnt_nxt;
  logic [2*DATA_W-1:0]   r_acc, w_acc_nxt;
  logic [2*DATA_W-1:0]   r_code, w_code_nxt;
  logic                  r_done, w_done_nxt;

  logic                  w_u, w_p0, w_p1;
  logic [2*DATA_W-1:0]   w_acc_shift;

  // Message is consumed from the top by shifting, so the current bit is always the MSB.
  // Pairs are shifted in at the bottom; after DATA_W steps the first pair sits at the top.
  assign w_u         = r_msg[DATA_W-1];
  assign w_p0        = ^({w_u, r_s1, r_s2} & G0);
  assign w_p1        = ^({w_u, r_s1, r_s2} & G1);
  assign w_acc_shift = {r_acc[2*DATA_W-3:0], w_p0, w_p1};

  always_comb begin
    w_state_nxt = r_state;
    w_msg_nxt   = r_msg;
    w_s1_nxt    = r_s1;
    w_s2_nxt    = r_s2;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_code_nxt  = r_code;
    w_done_nxt  = r_done;

    if (i_en) begin
      w_done_nxt = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_msg_nxt   = i_data_in;
            w_s1_nxt    = 1'b0;
            w_s2_nxt    = 1'b0;
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
            w_state_nxt = StEncode;
          end
        end
        StEncode: begin
          w_msg_nxt = {r_msg[DATA_W-2:0], 1'b0};
          w_s2_nxt  = r_s1;
          w_s1_nxt  = w_u;
          w_cnt_nxt = r_cnt + CntW'(1);
          w_acc_nxt = w_acc_shift;
          if (r_cnt == LastCnt) begin
            w_code_nxt  = w_acc_shift;
            w_done_nxt  = 1'b1;
            w_state_nxt = StDone;
          end
        end
        StDone: begin
          w_state_nxt = StIdle;
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_msg   <= '0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_code  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_msg   <= w_msg_nxt;
      r_s1    <= w_s1_nxt;
      r_s2    <= w_s2_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_code  <= w_code_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_code_out  = r_code;
  assign o_done_flag = r_done;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed vectors, stalls, aborts and randomized
// frames compared against a behavioural trellis model.
module tb_conv_encoder;

  localparam int unsigned DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic                start = 1'b0;
  logic [DATA_W-1:0]   data_in = '0;
  logic [2*DATA_W-1:0] code_out;
  logic                done_flag;
  logic                busy;

  int n_checks = 0;
  int n_errors = 0;

  conv_encoder #(.DATA_W(DATA_W), .G0(3'b111), .G1(3'b101)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_start     (start),
    .i_data_in   (data_in),
    .o_code_out  (code_out),
    .o_done_flag (done_flag),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: run the message through a 3-bit window {u, s1, s2}, two parity bits per step.
  function automatic logic [2*DATA_W-1:0] ref_encode(input logic [DATA_W-1:0] msg);
    int code = 0;
    int s1 = 0;
    int s2 = 0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      int u = (msg >> i) & 1;
      int p0 = (u + s1 + s2) % 2;
      int p1 = (u + s2) % 2;
      code = code * 4 + p0 * 2 + p1;
      s2 = s1;
      s1 = u;
    end
    return code[2*DATA_W-1:0];
  endfunction

  // Runs one frame; en is dropped for stall_len edges starting stall_at edges after start.
  task automatic frame(input string tag, input logic [DATA_W-1:0] d, input int stall_at,
                       input int stall_len, input bit restart, input bit hold_done);
    int lat;
    start   = 1'b1;
    data_in = d;
    tick();
    start   = 1'b0;
    data_in = DATA_W'($urandom);
    lat     = 0;
    while (!done_flag && lat < 60) begin
      check({tag, " busy"}, {31'b0, busy}, 32'd1);
      en    = !(lat >= stall_at && lat < stall_at + stall_len);
      start = restart && (lat == 3);
      tick();
      lat++;
    end
    start = 1'b0;
    en    = 1'b1;
    check({tag, " latency"}, lat, 8 + stall_len);
    check({tag, " code"}, {16'b0, code_out}, {16'b0, ref_encode(d)});
    if (hold_done) begin
      en = 1'b0;
      repeat (3) tick();
      check({tag, " done held"}, {31'b0, done_flag}, 32'd1);
      en = 1'b1;
    end
    tick();
    check({tag, " done pulse"}, {31'b0, done_flag}, 32'd0);
    check({tag, " idle"}, {31'b0, busy}, 32'd0);
    check({tag, " code hold"}, {16'b0, code_out}, {16'b0, ref_encode(d)});
  endtask

  initial begin
    // Reset takes priority even with en low.
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) tick();
    check("reset code", {16'b0, code_out}, 32'd0);
    check("reset done", {31'b0, done_flag}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    frame("zero", 8'h00, 99, 0, 1'b0, 1'b0);
    check("zero const", {16'b0, code_out}, 32'h0000);
    frame("b0", 8'hB0, 99, 0, 1'b0, 1'b0);
    check("b0 const", {16'b0, code_out}, 32'hE170);
    frame("impulse", 8'h80, 99, 0, 1'b0, 1'b0);
    check("impulse const", {16'b0, code_out}, 32'hEC00);
    frame("ones", 8'hFF, 99, 0, 1'b0, 1'b0);
    check("ones const", {16'b0, code_out}, 32'hDAAA);
    frame("b2b", 8'hB0, 99, 0, 1'b0, 1'b0);
    check("b2b const", {16'b0, code_out}, 32'hE170);

    frame("stall", 8'hFF, 3, 5, 1'b0, 1'b1);
    check("stall const", {16'b0, code_out}, 32'hDAAA);

    // Reset mid-frame: frame discarded, no done pulse.
    start   = 1'b1;
    data_in = 8'hB0;
    tick();
    start   = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort code", {16'b0, code_out}, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("abort no done", {31'b0, done_flag}, 32'd0);
    end

    // Reset and start together: stays idle.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst+start busy", {31'b0, busy}, 32'd0);
    tick();
    check("rst+start idle", {31'b0, busy}, 32'd0);

    frame("restart", 8'h80, 99, 0, 1'b1, 1'b0);
    check("restart const", {16'b0, code_out}, 32'hEC00);

    for (int m = 0; m < 256; m++) frame("sweep", m[7:0], 99, 0, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++)
      frame("rand", DATA_W'($urandom), $urandom_range(0, 7), $urandom_range(0, 4), 1'b0,
            1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
